// File: rtl/vga_scaled_pixel_pipeline.sv
// VGA timing, scaled framebuffer fetch, palette lookup and colour output in one block.
// Sync and enable are delayed to line up with the fetch and lookup pipeline.
module vga_scaled_pixel_pipeline #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int TOTAL_COLS    = 800,
  parameter int TOTAL_ROWS    = 525,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int V_FP          = 10,
  parameter int V_SYNC        = 2,
  parameter int SCALE         = 2,
  parameter int PIXEL_BITS    = 2,
  parameter int COLOR_BITS    = 4,
  parameter int MEM_LATENCY   = 1,
  localparam int SRC_W        = SCREEN_WIDTH / SCALE,
  localparam int SRC_H        = SCREEN_HEIGHT / SCALE,
  localparam int AW           = $clog2(SRC_W * SRC_H),
  localparam int L            = MEM_LATENCY + 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PIXEL_BITS-1:0]   fb_data,
  output logic                    fb_rd_en,
  output logic [AW-1:0]           fb_addr,
  input  logic                    pal_we,
  input  logic [PIXEL_BITS-1:0]   pal_addr,
  input  logic [3*COLOR_BITS-1:0] pal_data,
  output logic [COLOR_BITS-1:0]   red,
  output logic [COLOR_BITS-1:0]   green,
  output logic [COLOR_BITS-1:0]   blue,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    data_enable,
  output logic                    frame_pulse,
  output logic                    line_pulse
);

  localparam int XW = $clog2(TOTAL_COLS);
  localparam int YW = $clog2(TOTAL_ROWS);
  localparam int SS = $clog2(SCALE);
  localparam int CW = 3 * COLOR_BITS;

  localparam logic [XW-1:0] X_LAST     = XW'(TOTAL_COLS - 1);
  localparam logic [XW-1:0] X_VIS      = XW'(SCREEN_WIDTH);
  localparam logic [XW-1:0] X_LAST_VIS = XW'(SCREEN_WIDTH - 1);
  localparam logic [XW-1:0] HS_START   = XW'(SCREEN_WIDTH + H_FP);
  localparam logic [XW-1:0] HS_END     = XW'(SCREEN_WIDTH + H_FP + H_SYNC);
  localparam logic [XW-1:0] X_MASK     = XW'(SCALE - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(TOTAL_ROWS - 1);
  localparam logic [YW-1:0] Y_VIS      = YW'(SCREEN_HEIGHT);
  localparam logic [YW-1:0] VS_START   = YW'(SCREEN_HEIGHT + V_FP);
  localparam logic [YW-1:0] VS_END     = YW'(SCREEN_HEIGHT + V_FP + V_SYNC);
  localparam logic [YW-1:0] Y_MASK     = YW'(SCALE - 1);
  localparam logic [AW-1:0] LINE_STEP  = AW'(SRC_W);

  logic [XW-1:0] sx_q, sx_d;
  logic [YW-1:0] sy_q, sy_d;
  logic [AW-1:0] line_base_q, line_base_d;
  logic          started_q;

  logic visible;
  logic hs_raw;
  logic vs_raw;

  logic [MEM_LATENCY-1:0] rd_sr_q;
  logic [L-1:0]           de_sr_q;
  logic [L-1:0]           hs_sr_q;
  logic [L-1:0]           vs_sr_q;
  logic [PIXEL_BITS-1:0]  hold_q;
  logic [PIXEL_BITS-1:0]  pix;
  logic [CW-1:0]          lookup_q;
  logic [CW-1:0]          rgb_q;
  logic [CW-1:0]          pal_q [2**PIXEL_BITS];

  // started_q holds the counters at (0,0) for the first edge after reset and
  // suppresses fetches and strobes until then.
  assign visible     = started_q && (sx_q < X_VIS) && (sy_q < Y_VIS);
  assign fb_rd_en    = visible && ((sx_q & X_MASK) == '0);
  assign fb_addr     = line_base_q + AW'(sx_q >> SS);
  assign hs_raw      = !((sx_q >= HS_START) && (sx_q < HS_END));
  assign vs_raw      = !((sy_q >= VS_START) && (sy_q < VS_END));
  assign frame_pulse = started_q && (sx_q == '0) && (sy_q == '0);
  assign line_pulse  = started_q && (sx_q == '0);

  always_comb begin
    sx_d        = sx_q;
    sy_d        = sy_q;
    line_base_d = line_base_q;
    if (started_q) begin
      if (sx_q == X_LAST) begin
        sx_d = '0;
        sy_d = (sy_q == Y_LAST) ? '0 : sy_q + YW'(1);
      end else begin
        sx_d = sx_q + XW'(1);
      end
      if ((sx_q == X_LAST) && (sy_q == Y_LAST)) begin
        line_base_d = '0;
      end else if (visible && (sx_q == X_LAST_VIS) && ((sy_q & Y_MASK) == Y_MASK)) begin
        line_base_d = line_base_q + LINE_STEP;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sx_q        <= '0;
      sy_q        <= '0;
      line_base_q <= '0;
      started_q   <= 1'b0;
    end else begin
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      line_base_q <= line_base_d;
      started_q   <= 1'b1;
    end
  end

  // The freshly returned word bypasses the hold register so the lookup sees it
  // in the same cycle; replicated columns reuse the held index.
  assign pix = rd_sr_q[MEM_LATENCY-1] ? fb_data : hold_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_sr_q  <= '0;
      de_sr_q  <= '0;
      hs_sr_q  <= '1;
      vs_sr_q  <= '1;
      hold_q   <= '0;
      lookup_q <= '0;
      rgb_q    <= '0;
    end else begin
      rd_sr_q  <= MEM_LATENCY'({rd_sr_q, fb_rd_en});
      de_sr_q  <= L'({de_sr_q, visible});
      hs_sr_q  <= L'({hs_sr_q, hs_raw});
      vs_sr_q  <= L'({vs_sr_q, vs_raw});
      hold_q   <= pix;
      lookup_q <= pal_q[pix];
      rgb_q    <= de_sr_q[L-2] ? lookup_q : '0;
    end
  end

  // A write lands at the same edge as a lookup of that entry, so the lookup
  // still returns the previous contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2**PIXEL_BITS; i++) begin
        pal_q[i] <= (i == 0) ? '0 : '1;
      end
    end else if (pal_we) begin
      pal_q[pal_addr] <= pal_data;
    end
  end

  assign {red, green, blue} = rgb_q;
  assign hsync              = hs_sr_q[L-1];
  assign vsync              = vs_sr_q[L-1];
  assign data_enable        = de_sr_q[L-1];

endmodule

// File: tb/tb_vga_scaled_pixel_pipeline.sv
// Bench for vga_scaled_pixel_pipeline: a scaled, long-latency instance and an unscaled 1-bit
// instance share a reduced screen geometry, compared every cycle against a position-based model.
module tb_vga_scaled_pixel_pipeline;

  localparam int SW    = 16;
  localparam int SH    = 8;
  localparam int TC    = 24;
  localparam int TR    = 12;
  localparam int HFP   = 2;
  localparam int HSY   = 3;
  localparam int VFP   = 1;
  localparam int VSY   = 2;
  localparam int FRAME = TC * TR;

  localparam int SA    = 2;
  localparam int PBA   = 2;
  localparam int MLA   = 3;
  localparam int LA    = MLA + 2;
  localparam int SRCWA = SW / SA;
  localparam int SRCHA = SH / SA;
  localparam int AWA   = $clog2(SRCWA * SRCHA);

  localparam int SB    = 1;
  localparam int PBB   = 1;
  localparam int MLB   = 1;
  localparam int LB    = MLB + 2;
  localparam int AWB   = $clog2(SW * SH);

  logic clk = 1'b0;
  logic reset;

  logic [PBA-1:0] fbDataA;
  logic           fbRdEnA;
  logic [AWA-1:0] fbAddrA;
  logic           palWeA;
  logic [PBA-1:0] palAddrA;
  logic [11:0]    palDataA;
  logic [3:0]     redA, greenA, blueA;
  logic           hsyncA, vsyncA, deA, framePulseA, linePulseA;

  logic [PBB-1:0] fbDataB;
  logic           fbRdEnB;
  logic [AWB-1:0] fbAddrB;
  logic [3:0]     redB, greenB, blueB;
  logic           hsyncB, vsyncB, deB, framePulseB, linePulseB;

  logic [PBA-1:0] memA [SRCWA*SRCHA];
  logic [PBB-1:0] memB [SW*SH];
  logic [PBA-1:0] pipeA [MLA];
  logic [PBB-1:0] pipeB;

  logic [11:0] palModel [2**PBA];
  logic [11:0] expQ [$];
  int n;
  int checks;
  int failures;
  int rdCntA;
  int rdCntB;
  int collOut;
  bit collDone;

  always #5 clk = ~clk;

  vga_scaled_pixel_pipeline #(
    .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH), .TOTAL_COLS(TC), .TOTAL_ROWS(TR),
    .H_FP(HFP), .H_SYNC(HSY), .V_FP(VFP), .V_SYNC(VSY),
    .SCALE(SA), .PIXEL_BITS(PBA), .COLOR_BITS(4), .MEM_LATENCY(MLA)
  ) dutA (
    .clk(clk), .reset(reset), .fb_data(fbDataA), .fb_rd_en(fbRdEnA), .fb_addr(fbAddrA),
    .pal_we(palWeA), .pal_addr(palAddrA), .pal_data(palDataA),
    .red(redA), .green(greenA), .blue(blueA), .hsync(hsyncA), .vsync(vsyncA),
    .data_enable(deA), .frame_pulse(framePulseA), .line_pulse(linePulseA)
  );

  vga_scaled_pixel_pipeline #(
    .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH), .TOTAL_COLS(TC), .TOTAL_ROWS(TR),
    .H_FP(HFP), .H_SYNC(HSY), .V_FP(VFP), .V_SYNC(VSY),
    .SCALE(SB), .PIXEL_BITS(PBB), .COLOR_BITS(4), .MEM_LATENCY(MLB)
  ) dutB (
    .clk(clk), .reset(reset), .fb_data(fbDataB), .fb_rd_en(fbRdEnB), .fb_addr(fbAddrB),
    .pal_we(1'b0), .pal_addr(1'b0), .pal_data(12'h000),
    .red(redB), .green(greenB), .blue(blueB), .hsync(hsyncB), .vsync(vsyncB),
    .data_enable(deB), .frame_pulse(framePulseB), .line_pulse(linePulseB)
  );

  // Framebuffer RAMs with fixed read latency; non-read cycles return noise.
  always @(posedge clk) begin
    pipeA[0] <= fbRdEnA ? memA[fbAddrA] : PBA'($urandom);
    for (int i = 1; i < MLA; i++) pipeA[i] <= pipeA[i-1];
    pipeB <= fbRdEnB ? memB[fbAddrB] : PBB'($urandom);
  end
  assign fbDataA = pipeA[MLA-1];
  assign fbDataB = pipeB;

  // Position p counts cycles from the first frame_pulse; negative means none yet.
  function automatic bit isVisible(int p);
    return (p >= 0) && ((p % TC) < SW) && (((p / TC) % TR) < SH);
  endfunction

  function automatic bit hsOf(int p);
    int x;
    if (p < 0) return 1'b1;
    x = p % TC;
    return !((x >= SW + HFP) && (x < SW + HFP + HSY));
  endfunction

  function automatic bit vsOf(int p);
    int y;
    if (p < 0) return 1'b1;
    y = (p / TC) % TR;
    return !((y >= SH + VFP) && (y < SH + VFP + VSY));
  endfunction

  function automatic int srcAddr(int p, int s);
    return (((p / TC) % TR) / s) * (SW / s) + (p % TC) / s;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, n);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " rgbA"}, {redA, greenA, blueA}, 12'h000);
    checkOutput({tag, " syncA"}, {hsyncA, vsyncA, deA}, 3'b110);
    checkOutput({tag, " fetchA"}, {fbRdEnA, fbAddrA}, '0);
    checkOutput({tag, " pulseA"}, {framePulseA, linePulseA}, 2'b00);
    checkOutput({tag, " rgbB"}, {redB, greenB, blueB}, 12'h000);
    checkOutput({tag, " syncB"}, {hsyncB, vsyncB, deB}, 3'b110);
    checkOutput({tag, " fetchB"}, {fbRdEnB, fbAddrB}, '0);
  endtask

  task automatic restartModel();
    n = 0;
    palModel[0] = 12'h000;
    for (int i = 1; i < 2**PBA; i++) palModel[i] = 12'hFFF;
    expQ.delete();
    expQ.push_back(12'h000);
    expQ.push_back(12'h000);
    rdCntA = 0;
    rdCntB = 0;
  endtask

  task automatic checkCycle();
    int pA;
    int pB;
    int q;
    bit rdExpA;
    bit rdExpB;
    logic [11:0] colB;
    pA = n - LA;
    pB = n - LB;
    rdExpA = isVisible(n) && (((n % TC) % SA) == 0);
    rdExpB = isVisible(n);

    if (n > 0 && (n % FRAME) == 0) begin
      checkOutput("readsPerFrameA", rdCntA, SRCWA * SH);
      checkOutput("readsPerFrameB", rdCntB, SW * SH);
      rdCntA = 0;
      rdCntB = 0;
    end
    rdCntA += int'(fbRdEnA);
    rdCntB += int'(fbRdEnB);

    checkOutput("rdEnA", fbRdEnA, rdExpA);
    if (rdExpA) checkOutput("addrA", fbAddrA, srcAddr(n, SA));
    checkOutput("framePulseA", framePulseA, (n % FRAME) == 0);
    checkOutput("linePulseA", linePulseA, (n % TC) == 0);
    checkOutput("hsyncA", hsyncA, hsOf(pA));
    checkOutput("vsyncA", vsyncA, vsOf(pA));
    checkOutput("deA", deA, isVisible(pA));
    checkOutput("rgbA", {redA, greenA, blueA}, expQ.pop_front());

    if (n == collOut) checkOutput("collisionOld", {redA, greenA, blueA}, 12'hFFF);
    if (n == collOut + 1) begin
      checkOutput("collisionNew", {redA, greenA, blueA}, 12'hF00);
      collOut = -100;
    end

    checkOutput("rdEnB", fbRdEnB, rdExpB);
    if (rdExpB) checkOutput("addrB", fbAddrB, srcAddr(n, SB));
    checkOutput("framePulseB", framePulseB, (n % FRAME) == 0);
    checkOutput("hsyncB", hsyncB, hsOf(pB));
    checkOutput("vsyncB", vsyncB, vsOf(pB));
    checkOutput("deB", deB, isVisible(pB));
    colB = (isVisible(pB) && memB[srcAddr(pB, SB)] == 1'b1) ? 12'hFFF : 12'h000;
    checkOutput("rgbB", {redB, greenB, blueB}, colB);

    // Colour two cycles ahead is the palette as it stands now, indexed by that position's source pixel.
    q = n + 2 - LA;
    expQ.push_back(isVisible(q) ? palModel[memA[srcAddr(q, SA)]] : 12'h000);
  endtask

  // Palette writes: one directed write colliding with a lookup of entry 1,
  // then random writes from the second frame on.
  task automatic applyStimulus();
    int q;
    q = n - MLA;
    palWeA = 1'b0;
    if (!collDone && isVisible(q) && (((q % TC) % SA) == 0) && memA[srcAddr(q, SA)] == 2'd1) begin
      palWeA   = 1'b1;
      palAddrA = 2'd1;
      palDataA = 12'hF00;
      collDone = 1'b1;
      collOut  = n + 2;
    end else if (n >= FRAME && $urandom_range(7) == 0) begin
      palWeA   = 1'b1;
      palAddrA = PBA'($urandom);
      palDataA = 12'($urandom);
    end
    if (palWeA) palModel[palAddrA] = palDataA;
  endtask

  task automatic runCycles(input int count);
    repeat (count) begin
      @(posedge clk);
      @(negedge clk);
      checkCycle();
      applyStimulus();
      n++;
    end
  endtask

  initial begin
    int resetAt;
    checks   = 0;
    failures = 0;
    collOut  = -100;
    collDone = 1'b0;
    for (int i = 0; i < SRCWA * SRCHA; i++) memA[i] = PBA'($urandom);
    memA[2] = 2'd1;
    for (int i = 0; i < SW * SH; i++) memB[i] = PBB'($urandom);
    palWeA   = 1'b0;
    palAddrA = '0;
    palDataA = '0;
    reset    = 1'b1;

    $display("[TB] power-on reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkReset("powerOn");
    reset = 1'b0;
    #1 checkReset("firstCycle");
    restartModel();

    resetAt = 2 * FRAME + $urandom_range(SH - 1) * TC + $urandom_range(SW - 1);
    $display("[TB] running to mid-frame reset at cycle %0d", resetAt);
    runCycles(resetAt);

    @(posedge clk);
    @(negedge clk);
    reset  = 1'b1;
    palWeA = 1'b0;
    #1 checkReset("midReset");
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      checkReset("holdReset");
    end
    reset = 1'b0;
    #1 checkReset("afterRelease");
    restartModel();

    $display("[TB] running after mid-frame reset");
    runCycles(2 * FRAME + 20);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
